// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Every datapath control in one word so a single default clears them all.
  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       load_half;
    logic       load_half_unsigned;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_dbg;
  } ctl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) || (op == OP_SW);
  endfunction

  function automatic logic is_alu_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control/status bundle between sequencer and datapath
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       load_half;
  logic       load_half_unsigned;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           load_half, load_half_unsigned, trap, trap_cause, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           load_half, load_half_unsigned, trap, trap_cause, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm_wait_timer.sv
// rtl/multicycle_control_fsm_wait_timer.sv - memory wait counter with limit detection
module mips_ctrl_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic limit_hit
);

  // The count holds completed wait cycles, so the current cycle is the
  // WAIT_LIMIT-th wait when the count equals WAIT_LIMIT-1.
  localparam int              LAST_I = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;
  localparam logic [CNT_W-1:0] LAST  = LAST_I[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit = (WAIT_LIMIT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore sequencer driving the multi-cycle MIPS datapath
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_fsm_if.master bus
);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [1:0] cause_q, cause_d;
  ctl_t       ctl;
  logic       wait_state;
  logic       timer_clr;
  logic       limit_hit;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  // Leaving any state restarts the count, which covers entry into each wait state.
  assign timer_clr  = (state_d != state_q) || !wait_state;

  mips_ctrl_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (reset),
    .clr       (timer_clr),
    .en        (wait_state && !bus.mem_ready),
    .limit_hit (limit_hit)
  );

  // Next-state, opcode latch, trap cause and per-state control word.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cause_d = cause_q;
    ctl     = '0;
    ctl.state_dbg = state_q;

    unique case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_OP_ADD;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else if (limit_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SH2;
        ctl.alu_op    = ALU_OP_ADD;
        op_d          = bus.opcode;
        if (is_mem_op(bus.opcode)) begin
          state_d = S_MEM_ADDR;
        end else if (is_alu_op(bus.opcode)) begin
          state_d = S_EXECUTE;
        end else if (bus.opcode == OP_BEQ) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_OP_ADD;
        state_d       = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (limit_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WB: begin
        ctl.reg_write          = 1'b1;
        ctl.mem_to_reg         = 1'b1;
        ctl.load_half          = (op_q == OP_LH);
        ctl.load_half_unsigned = (op_q == OP_LHU);
        state_d                = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (limit_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_OP_FUNCT;
        ctl.alu_src_b = (op_q == OP_RTYPE) ? SRCB_B : SRCB_IMM;
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = (op_q == OP_RTYPE);
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALU_OP_SUB;
        ctl.pc_source = 1'b1;
        ctl.pc_write  = bus.zero;
        state_d       = S_FETCH;
      end
      S_TRAP: begin
        ctl.trap       = 1'b1;
        ctl.trap_cause = cause_q;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset silences the datapath immediately, not at the next edge.
    if (reset) begin
      ctl = '0;
    end
  end

  // State, latched opcode and sticky trap cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cause_q <= cause_d;
    end
  end

  assign bus.pc_write           = ctl.pc_write;
  assign bus.pc_source          = ctl.pc_source;
  assign bus.i_or_d             = ctl.i_or_d;
  assign bus.mem_read           = ctl.mem_read;
  assign bus.mem_write          = ctl.mem_write;
  assign bus.ir_write           = ctl.ir_write;
  assign bus.reg_dst            = ctl.reg_dst;
  assign bus.reg_write          = ctl.reg_write;
  assign bus.mem_to_reg         = ctl.mem_to_reg;
  assign bus.alu_src_a          = ctl.alu_src_a;
  assign bus.alu_src_b          = ctl.alu_src_b;
  assign bus.alu_op             = ctl.alu_op;
  assign bus.load_half          = ctl.load_half;
  assign bus.load_half_unsigned = ctl.load_half_unsigned;
  assign bus.trap               = ctl.trap;
  assign bus.trap_cause         = ctl.trap_cause;
  assign bus.state_dbg          = ctl.state_dbg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for the multi-cycle control sequencer
module tb_multicycle_control_fsm;

  localparam int LIMIT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bif ();

  multicycle_control_fsm #(
    .WAIT_LIMIT (LIMIT),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       load_half;
    logic       load_half_unsigned;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_dbg;
  } ctl_t;

  typedef struct {
    ctl_t v;
    int   tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tag   = 0;

  logic [5:0] legal_ops [9] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h23, 6'h21, 6'h25, 6'h2B};

  // Reference: what the datapath must see in a given step of an instruction.
  // Step numbers are the externally visible state_dbg codes.
  function automatic ctl_t model(int st, logic [5:0] op, bit rdy, bit z, logic [1:0] cause);
    ctl_t c;
    c = '0;
    c.state_dbg = 4'(st);
    case (st)
      0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1: c.alu_src_b = 2'b11;
      2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3: begin c.mem_read = 1; c.i_or_d = 1; end
      4: begin
        c.reg_write = 1; c.mem_to_reg = 1;
        c.load_half = (op == 6'h21); c.load_half_unsigned = (op == 6'h25);
      end
      5: begin c.mem_write = 1; c.i_or_d = 1; end
      6: begin c.alu_src_a = 1; c.alu_op = 2'b10; c.alu_src_b = (op == 6'h00) ? 2'b00 : 2'b10; end
      7: begin c.reg_write = 1; c.reg_dst = (op == 6'h00); end
      8: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 1; c.pc_write = z; end
      9: begin c.trap = 1; c.trap_cause = cause; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic step(bit rst, logic [5:0] opc, bit z, bit rdy, ctl_t e);
    exp_t x;
    @(posedge clk);
    #1;
    reset         = rst;
    bif.opcode    = opc;
    bif.zero      = z;
    bif.mem_ready = rdy;
    x.v   = e;
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  // Outside DECODE the opcode bus carries garbage, so only the latched copy can be trusted.
  task automatic stp(int st, logic [5:0] op, bit rdy, bit z, logic [1:0] cause);
    logic [5:0] drv;
    drv = (st == 1) ? op : 6'($urandom);
    step(1'b0, drv, z, rdy, model(st, op, rdy, z, cause));
  endtask

  task automatic do_reset();
    step(1'b1, 6'($urandom), 1'($urandom), 1'($urandom), '0);
  endtask

  task automatic trap_hold(logic [1:0] cause, int n);
    for (int i = 0; i < n; i++) stp(9, 6'h00, 1'($urandom), 1'($urandom), cause);
    do_reset();
  endtask

  // A memory-facing step: `waits` cycles without ready, then ready, unless the limit runs out first.
  task automatic wait_state(int st, logic [5:0] op, int waits, output bit trapped);
    bit rdy;
    trapped = 0;
    for (int i = 0; i < 64; i++) begin
      rdy = (i >= waits);
      stp(st, op, rdy, 1'($urandom), 2'b00);
      if (rdy) break;
      if (i + 1 == LIMIT) begin
        trapped = 1;
        break;
      end
    end
  endtask

  task automatic run_instr(logic [5:0] op, int wf, int wm, bit z);
    bit tr;
    tag++;
    wait_state(0, op, wf, tr);
    if (tr) begin trap_hold(2'b10, 3); return; end
    stp(1, op, 1'($urandom), 1'($urandom), 2'b00);
    case (op)
      6'h23, 6'h21, 6'h25, 6'h2B: begin
        stp(2, op, 1'($urandom), 1'($urandom), 2'b00);
        if (op == 6'h2B) begin
          wait_state(5, op, wm, tr);
          if (tr) trap_hold(2'b10, 3);
        end else begin
          wait_state(3, op, wm, tr);
          if (tr) trap_hold(2'b10, 3);
          else stp(4, op, 1'($urandom), 1'($urandom), 2'b00);
        end
      end
      6'h00, 6'h08, 6'h0C, 6'h0D: begin
        stp(6, op, 1'($urandom), 1'($urandom), 2'b00);
        stp(7, op, 1'($urandom), 1'($urandom), 2'b00);
      end
      6'h04: stp(8, op, 1'($urandom), z, 2'b00);
      default: trap_hold(2'b01, 20);
    endcase
  endtask

  function automatic bit is_legal(logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1;
    return 0;
  endfunction

  // Monitor: every cycle the DUT presents a control word; pop and compare.
  exp_t me;
  ctl_t ma;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        ma = {bif.pc_write, bif.pc_source, bif.i_or_d, bif.mem_read, bif.mem_write,
              bif.ir_write, bif.reg_dst, bif.reg_write, bif.mem_to_reg, bif.alu_src_a,
              bif.alu_src_b, bif.alu_op, bif.load_half, bif.load_half_unsigned,
              bif.trap, bif.trap_cause, bif.state_dbg};
        n_vec++;
        if (ma !== me.v) begin
          n_bad++;
          $display("FAIL ctl instr=%0d got=%h (state %0d) expected=%h (state %0d)",
                   me.tag, ma, ma.state_dbg, me.v, me.v.state_dbg);
        end
        n_vec++;
        if (ma.mem_read && ma.mem_write) begin
          n_bad++;
          $display("FAIL rd_wr_excl instr=%0d got=both expected=at most one", me.tag);
        end
        n_vec++;
        if (ma.pc_write && ma.reg_write) begin
          n_bad++;
          $display("FAIL pc_reg_excl instr=%0d got=both expected=at most one", me.tag);
        end
      end
    end
  end

  initial begin
    logic [5:0] op;
    bit tr;
    bif.opcode    = 6'h00;
    bif.zero      = 1'b0;
    bif.mem_ready = 1'b0;

    do_reset();
    run_instr(6'h00, 0, 0, 0);
    run_instr(6'h21, 0, 3, 0);
    run_instr(6'h25, 1, 0, 0);
    run_instr(6'h04, 0, 0, 1);
    run_instr(6'h04, 2, 0, 0);
    run_instr(6'h3F, 0, 0, 0);
    run_instr(6'h2B, 0, 15, 0);
    run_instr(6'h2B, 0, 14, 0);
    run_instr(6'h23, 0, 15, 0);
    run_instr(6'h00, 15, 0, 0);
    run_instr(6'h08, 14, 0, 0);

    // Reset while a load is waiting on memory.
    tag++;
    wait_state(0, 6'h23, 0, tr);
    stp(1, 6'h23, 1'b0, 1'b0, 2'b00);
    stp(2, 6'h23, 1'b0, 1'b0, 2'b00);
    stp(3, 6'h23, 1'b0, 1'b0, 2'b00);
    stp(3, 6'h23, 1'b0, 1'b0, 2'b00);
    do_reset();
    run_instr(6'h00, 14, 0, 0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      run_instr(op,
                ($urandom_range(0, 7) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 3),
                1'($urandom));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain got=%0d pending expected=0 pending", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style sequencer for the multi-cycle MIPS datapath: shared memory port, single ALU, IR/MDR/A/B/ALUOut registers.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath mux and enable.
- Supports R-type, addi, lw, sw, lh, lhu, andi, ori and beq.
- Adds a memory ready handshake with timeout, and a sticky trap on illegal opcodes or memory timeout.

Parameters:
- WAIT_LIMIT, 15: maximum cycles in a memory state without mem_ready before trapping; 0 disables the timeout.
- CNT_W, 4: wait-counter width; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current read/write this cycle
- pc_write  out  1  PC load enable
- pc_source  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
- i_or_d  out  1  memory address mux: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dst  out  1  destination register mux: 1 = rd, 0 = rt
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  writeback mux: 1 = MDR, 0 = ALUOut
- alu_src_a  out  1  ALU A mux: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B mux: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct/opcode decode by ALU control
- load_half  out  1  lh sign-extend select
- load_half_unsigned  out  1  lhu zero-extend select
- trap  out  1  sticky error indication
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- While reset is high, or in any state, every output not listed for that state is 0. The first edge after reset release is evaluated in FETCH. Reset mid-instruction abandons the instruction and clears trap, trap_cause, the latched opcode and the wait counter.
- State encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4
  - MEM_WRITE = 5, EXECUTE = 6, ALU_WB = 7, BRANCH = 8, TRAP = 9
- FETCH:
  - Drives mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00.
  - If mem_ready: ir_write = 1, pc_write = 1, pc_source = 0 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 11, alu_op = 00.
  - Latches opcode into op_q.
  - Next state: 0x23/0x21/0x25/0x2B → MEM_ADDR; 0x00/0x08/0x0C/0x0D → EXECUTE; 0x04 → BRANCH; any other opcode → TRAP with cause 01.
- MEM_ADDR:
  - Drives alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Next state: MEM_WRITE if op_q = 0x2B, else MEM_READ.
- MEM_READ:
  - Drives mem_read = 1, i_or_d = 1.
  - Waits for mem_ready, then goes to MEM_WB.
- MEM_WB:
  - Drives reg_write = 1, mem_to_reg = 1, reg_dst = 0.
  - load_half = 1 if op_q = 0x21; load_half_unsigned = 1 if op_q = 0x25.
  - Next state: FETCH.
- MEM_WRITE:
  - Drives mem_write = 1, i_or_d = 1.
  - Waits for mem_ready, then goes to FETCH.
- EXECUTE:
  - Drives alu_src_a = 1 and alu_op = 10; alu_src_b = 00 for op_q = 0x00, else 10.
  - Next state: ALU_WB.
- ALU_WB:
  - Drives reg_write = 1, mem_to_reg = 0; reg_dst = 1 only for op_q = 0x00.
  - Next state: FETCH.
- BRANCH:
  - Drives alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 1, pc_write = zero (same cycle).
  - Next state: FETCH.
- TRAP:
  - All control outputs 0; trap = 1; trap_cause is held.
  - Only reset exits TRAP.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE; increments each cycle spent in those states with mem_ready = 0.
  - When the count equals WAIT_LIMIT with mem_ready = 0, go to TRAP with cause 10.
  - mem_ready on the limit cycle wins: normal transition, no trap.
- Latency with zero-wait memory: R-type/addi/andi/ori = 4 cycles, lw/lh/lhu = 5, sw = 4, beq = 3. Each wait cycle adds 1.
- mem_read and mem_write are never asserted together. pc_write and reg_write are never asserted in the same cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_LH, OP_LHU, OP_ANDI, OP_ORI, OP_BEQ)
  - the state enum/localparams
  - ALU_OP_* and SRCB_* encodings
  - trap-cause codes
- One sub-module, mips_ctrl_wait_timer (clear, count enable, limit-hit output), instantiated once.

Test Plan:
- R-type (opcode 0x00), mem_ready held 1 → states 0,1,6,7,0; reg_dst = reg_write = 1 in ALU_WB; alu_src_b = 00 and alu_op = 10 in EXECUTE.
- lh (0x21), mem_ready low for 3 cycles in MEM_READ → 8 cycles total; load_half = 1 and mem_to_reg = 1 only in MEM_WB; load_half_unsigned = 0.
- beq (0x04): zero = 1 gives pc_write = pc_source = 1 in BRANCH; zero = 0 gives pc_write = 0; both return to FETCH after 3 cycles.
- Opcode 0x3F at DECODE → TRAP, trap = 1, trap_cause = 01; outputs stay 0 for 20 cycles; reset clears to FETCH.
- sw (0x2B) with WAIT_LIMIT = 15 and mem_ready never asserted in MEM_WRITE → TRAP cause 10 after 15 wait cycles. Repeat with mem_ready on the 15th cycle → FETCH, no trap.
- Assert reset in MEM_READ while waiting → all outputs 0 immediately; after release FETCH with mem_read = 1, counter cleared.
